// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, writeback control bits, MEM FSM state.
// Imported by the MEM stage and its MEM/WB register.
package pipe_pkg;
  localparam int WB_CTL_W    = 2;
  localparam int M_CTL_W     = 3;
  localparam int REG_W       = 5;
  localparam int DATA_W      = 32;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. i_load captures all fields; i_bubble clears ctl.
// Ports: clk, rst, i_load, i_bubble, i_* fields in, o_* fields out.
module mem_wb #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic                         i_bubble,
  input  logic [pipe_pkg::WB_CTL_W-1:0] i_wb_ctl,
  input  logic [DATA_W-1:0]            i_rdata,
  input  logic [DATA_W-1:0]            i_alu,
  input  logic [REG_W-1:0]             i_dest,
  output logic [pipe_pkg::WB_CTL_W-1:0] o_wb_ctl,
  output logic [DATA_W-1:0]            o_rdata,
  output logic [DATA_W-1:0]            o_alu,
  output logic [REG_W-1:0]             o_dest
);
  import pipe_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wb_ctl <= '0;
      o_rdata  <= '0;
      o_alu    <= '0;
      o_dest   <= '0;
    end else if (i_load) begin
      o_wb_ctl <= i_wb_ctl;
      o_rdata  <= i_rdata;
      o_alu    <= i_alu;
      o_dest   <= i_dest;
    end else if (i_bubble) begin
      // stalled edge: keep data, kill the writeback
      o_wb_ctl <= '0;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolve, multi-cycle dmem req/ack with timeout, MEM/WB.
// Ports: EX/MEM fields in; pcsrc/target/stall out; dmem_*; MEM/WB out; mem_err.
module mem_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_ctl,
  input  logic              branch,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] ex_mem_npc,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [REG_W-1:0]  dest_reg,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [1:0]        mem_wb_ctl,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic              mem_err
);
  import pipe_pkg::*;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic [CNT_W-1:0]  r_wait;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  logic              w_memop;
  logic              w_idle;
  logic              w_acc;
  logic              w_start;
  logic              w_done;
  logic              w_timeout;
  logic              w_load;
  logic [1:0]        w_wb_ctl;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_alu;
  logic [REG_W-1:0]  w_dest;

  assign pcsrc         = branch & zero;
  assign branch_target = ex_mem_npc;

  assign w_memop   = memread | memwrite;
  assign w_idle    = (r_state == IDLE);
  assign w_acc     = (r_state == ACCESS);
  assign w_start   = w_idle & w_memop;
  assign w_done    = w_acc & dmem_ack;
  // ack on the final wait cycle wins over the abort
  assign w_timeout = w_acc & ~dmem_ack
                   & (r_wait == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_memop) w_next = ACCESS;
      ACCESS: if (dmem_ack | w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = w_acc;
    mem_stall = w_start | (w_acc & ~dmem_ack & ~w_timeout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_wait  <= '0;
      r_we    <= memwrite;
      r_addr  <= alu_result;
      r_wdata <= rdata2;
    end else if (w_acc & ~dmem_ack & ~w_timeout) begin
      r_wait  <= r_wait + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = r_err;

  // an aborted access retires as an all-zero bubble
  assign w_load   = (w_idle & ~w_memop) | w_done | w_timeout;
  assign w_wb_ctl = w_timeout ? 2'b00 : wb_ctl;
  assign w_alu    = w_timeout ? '0 : alu_result;
  assign w_dest   = w_timeout ? '0 : dest_reg;
  assign w_rdata  = (w_done & ~r_we) ? dmem_rdata : '0;

  mem_wb #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_bubble (mem_stall),
    .i_wb_ctl (w_wb_ctl),
    .i_rdata  (w_rdata),
    .i_alu    (w_alu),
    .i_dest   (w_dest),
    .o_wb_ctl (mem_wb_ctl),
    .o_rdata  (read_data),
    .o_alu    (mem_alu_result),
    .o_dest   (mem_write_reg)
  );
endmodule
